// File: rtl/rgb_mem_if.sv
// Bundle of core-port, display-port and plane-memory signals for the RGB memory arbiter.
// The arbiter uses the slave view; the environment (core, display, memories) uses the master view.
interface rgb_mem_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    // Core side
    logic                  c_req;
    logic                  c_we;
    logic [1:0]            c_rgb;
    logic [ADDR_W-1:0]     c_addr;
    logic [DATA_W-1:0]     c_wdata;
    logic [DATA_W-1:0]     c_rdata;
    logic                  c_done;
    logic                  stall;
    // Display side
    logic                  d_req;
    logic [ADDR_W-1:0]     d_addr;
    logic [3*DATA_W-1:0]   d_pixel;
    logic                  d_valid;
    // Shared plane-memory bus, per-plane vectors ordered {B,G,R}
    logic [ADDR_W-1:0]     m_addr;
    logic [DATA_W-1:0]     m_wdata;
    logic [2:0]            m_en;
    logic [2:0]            m_we;
    logic [DATA_W-1:0]     m_rdata_r;
    logic [DATA_W-1:0]     m_rdata_g;
    logic [DATA_W-1:0]     m_rdata_b;

    modport slave (
        input  c_req, c_we, c_rgb, c_addr, c_wdata,
        output c_rdata, c_done, stall,
        input  d_req, d_addr,
        output d_pixel, d_valid,
        output m_addr, m_wdata, m_en, m_we,
        input  m_rdata_r, m_rdata_g, m_rdata_b
    );

    modport master (
        output c_req, c_we, c_rgb, c_addr, c_wdata,
        input  c_rdata, c_done, stall,
        output d_req, d_addr,
        input  d_pixel, d_valid,
        input  m_addr, m_wdata, m_en, m_we,
        output m_rdata_r, m_rdata_g, m_rdata_b
    );
endinterface

// File: rtl/rgb_mem_arbiter.sv
// Arbiter sharing three colour-plane memories between a CPU core port and a display
// read port. One access takes three cycles: IDLE (arbitrate), ACCESS (drive planes),
// DONE (capture read data, pulse completion). Display has priority on conflict, but
// the core is granted after three consecutive lost conflicts so it cannot starve.
module rgb_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    rgb_mem_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                state_q;
    logic [1:0]            starve_q;
    logic                  grant_core_q;
    logic                  we_q;
    logic [1:0]            rgb_q;
    logic [ADDR_W-1:0]     m_addr_q;
    logic [DATA_W-1:0]     m_wdata_q;
    logic [2:0]            m_en_q;
    logic [2:0]            m_we_q;
    logic                  c_done_q;
    logic                  d_valid_q;
    logic [DATA_W-1:0]     c_rdata_q;
    logic [3*DATA_W-1:0]   d_pixel_q;

    logic                  grant_core_d;
    logic [2:0]            core_en_d;
    logic [DATA_W-1:0]     core_sel_d;
    logic [3*DATA_W-1:0]   pixel_d;
    logic                  core_read_done;
    logic                  disp_read_done;

    // Arbitration decision and plane decode for the request presented in IDLE
    always_comb begin
        grant_core_d = bus.c_req && (!bus.d_req || (starve_q == 2'd3));
        core_en_d    = 3'b000;
        case (bus.c_rgb)
            2'b01:   core_en_d = 3'b001;
            2'b10:   core_en_d = 3'b010;
            2'b11:   core_en_d = 3'b100;
            default: core_en_d = 3'b000;
        endcase
    end

    // Read-data select for the latched core plane; plane 00 reads as zero
    always_comb begin
        core_sel_d = '0;
        case (rgb_q)
            2'b01:   core_sel_d = bus.m_rdata_r;
            2'b10:   core_sel_d = bus.m_rdata_g;
            2'b11:   core_sel_d = bus.m_rdata_b;
            default: core_sel_d = '0;
        endcase
    end

    assign pixel_d        = {bus.m_rdata_r, bus.m_rdata_g, bus.m_rdata_b};
    assign core_read_done = (state_q == DONE) && grant_core_q && !we_q;
    assign disp_read_done = (state_q == DONE) && !grant_core_q;

    // Access sequencer: latch winner, drive planes for one cycle, then capture and complete
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            starve_q     <= 2'd0;
            grant_core_q <= 1'b0;
            we_q         <= 1'b0;
            rgb_q        <= 2'b00;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            m_en_q       <= 3'b000;
            m_we_q       <= 3'b000;
            c_done_q     <= 1'b0;
            d_valid_q    <= 1'b0;
            c_rdata_q    <= '0;
            d_pixel_q    <= '0;
        end else begin
            c_done_q  <= 1'b0;
            d_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.c_req || bus.d_req) begin
                        state_q      <= ACCESS;
                        grant_core_q <= grant_core_d;
                        if (grant_core_d) begin
                            we_q      <= bus.c_we;
                            rgb_q     <= bus.c_rgb;
                            m_addr_q  <= bus.c_addr;
                            m_wdata_q <= bus.c_wdata;
                            m_en_q    <= core_en_d;
                            m_we_q    <= bus.c_we ? core_en_d : 3'b000;
                            starve_q  <= 2'd0;
                        end else begin
                            we_q     <= 1'b0;
                            rgb_q    <= 2'b00;
                            m_addr_q <= bus.d_addr;
                            m_en_q   <= 3'b111;
                            m_we_q   <= 3'b000;
                            // Count only conflicts the display won; a lone display request resets it
                            starve_q <= bus.c_req ? (starve_q + 2'd1) : 2'd0;
                        end
                    end
                end
                ACCESS: begin
                    m_en_q  <= 3'b000;
                    m_we_q  <= 3'b000;
                    state_q <= DONE;
                    if (grant_core_q) begin
                        c_done_q <= 1'b1;
                    end else begin
                        d_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    if (core_read_done) begin
                        c_rdata_q <= core_sel_d;
                    end
                    if (disp_read_done) begin
                        d_pixel_q <= pixel_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Read data is passed straight through during DONE so it is valid alongside the pulse
    assign bus.c_rdata = core_read_done ? core_sel_d : c_rdata_q;
    assign bus.d_pixel = disp_read_done ? pixel_d : d_pixel_q;
    assign bus.c_done  = c_done_q;
    assign bus.d_valid = d_valid_q;
    assign bus.stall   = bus.c_req && !c_done_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.m_en    = m_en_q;
    assign bus.m_we    = m_we_q;

endmodule

// File: doc/rgb_mem_arbiter.md
RGB_MEM_ARBITER -- requirements
Module: rgb_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, SHALL set the width of the color-memory word address.
REQ-002 Parameter DATA_W, default 8, SHALL set the width of one color-plane word; the pixel width is 3*DATA_W.
REQ-003 Clocking SHALL be one clock, clk; reset rst_n is asynchronous and active-low.
REQ-004 clk  in  1  sole clock; all state changes on the rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 c_req  in  1  core memory request; held high until c_done.
REQ-007 c_we  in  1  core write (1) / read (0); stable while c_req.
REQ-008 c_rgb  in  2  plane select: 01 R, 10 G, 11 B, 00 none (same encoding as the decoder RGB output).
REQ-009 c_addr  in  ADDR_W  core address.
REQ-010 c_wdata  in  DATA_W  core write data.
REQ-011 c_rdata  out  DATA_W  core read data, valid while c_done.
REQ-012 c_done  out  1  one-cycle completion pulse for the core access.
REQ-013 stall  out  1  pipeline stall: c_req AND NOT c_done (combinational).
REQ-014 d_req  in  1  display read request; held until d_valid.
REQ-015 d_addr  in  ADDR_W  display pixel address.
REQ-016 d_pixel  out  3*DATA_W  {R,G,B}, valid while d_valid.
REQ-017 d_valid  out  1  one-cycle completion pulse for the display read.
REQ-018 m_addr  out  ADDR_W  shared address to the three planes.
REQ-019 m_wdata  out  DATA_W  shared write data.
REQ-020 m_en  out  3  per-plane enable {B,G,R}.
REQ-021 m_we  out  3  per-plane write enable {B,G,R}; subset of m_en.
REQ-022 m_rdata_r, m_rdata_g, m_rdata_b  in  DATA_W each  plane read data, registered, one cycle after the enable.

Function
REQ-023 The FSM SHALL have three states: IDLE, ACCESS and DONE.
REQ-024 IDLE: with no request, the FSM SHALL stay in IDLE. With any request, it SHALL arbitrate, latch the winner's fields, and go to ACCESS.
REQ-025 ACCESS SHALL drive m_addr, m_wdata, m_en and m_we from the latched fields for exactly one cycle, then go to DONE.
REQ-026 DONE SHALL capture read data, pulse the winner's done/valid for one cycle, and return to IDLE unconditionally.
REQ-027 Latency from request sampled in IDLE to done/valid SHALL be 3 cycles; maximum throughput is one access per 3 cycles.
REQ-028 A core access SHALL enable only the plane selected by c_rgb; m_we equals m_en when c_we=1, else 0.
REQ-029 A display access SHALL enable all three planes with m_we=000.
REQ-030 c_rgb=00 SHALL complete normally with m_en=000 and c_rdata=0 (no-op); a write with c_rgb=00 modifies no memory.
REQ-031 In DONE: core reads load c_rdata from the selected plane; display reads load d_pixel={m_rdata_r,m_rdata_g,m_rdata_b}.
REQ-032 c_rdata and d_pixel SHALL hold their last values until the next capture; after a core write, c_rdata is unchanged.
REQ-033 Arbitration SHALL grant the sole requester when only one requests.
REQ-034 On conflict, display SHALL win unless starve_cnt=3, in which case core wins.
REQ-035 starve_cnt (2-bit) SHALL increment on each conflict won by display and clear when core wins or when core is not requesting at arbitration.
REQ-036 A requester SHALL deassert req in the cycle after its done/valid; a req still high in IDLE is treated as a new request.
REQ-037 Request inputs SHALL be ignored outside IDLE; m_en and m_we SHALL be 000 in every state except ACCESS.

Reset
REQ-038 rst_n low SHALL immediately force: state IDLE, starve_cnt 0, m_en/m_we 000, m_addr/m_wdata 0, c_done/d_valid 0, c_rdata/d_pixel 0.
REQ-039 Reset asserted in ACCESS or DONE SHALL abort the access with no done/valid pulse; a write aborted during ACCESS may leave the plane undefined.

Verification
REQ-040 Core write, c_rgb=10, addr 0x0012, data 0x5A -> m_en=010 and m_we=010 in cycle 2; c_done in cycle 3; stall high in cycles 1-2.
REQ-041 Core read, c_rgb=11, addr 0x0012, with m_rdata_b=0x3C -> m_en=100, m_we=000; c_rdata=0x3C with c_done in cycle 3.
REQ-042 Display read, addr 0x0100, with R/G/B returning 0x11/0x22/0x33 -> m_en=111, m_we=000; d_pixel=0x112233 with d_valid in cycle 3.
REQ-043 Core and display both continuously requesting -> grant order D,D,D,C,D,D,D,C; stall never exceeds 12 cycles.
REQ-044 c_rgb=00 write -> m_en stays 000 for all cycles; c_done in cycle 3; c_rdata=0.
REQ-045 rst_n pulled low in ACCESS -> m_en=000 in the same cycle; no c_done or d_valid pulse; the next request after reset completes in 3 cycles.
